// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs register fields, opcode/funct and an immediate into a
// 32-bit instruction word, two-stage valid/ready pipeline with auto-incrementing word address.
`timescale 1ns/1ps

module instr_encoder #(
    parameter int          ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    function automatic logic in_range(
        input logic signed [31:0] v,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    // Immediate must fit the format's field; B/J offsets must also be halfword aligned.
    function automatic logic imm_err(
        input logic        [2:0]  fmt,
        input logic signed [31:0] imm
    );
        case (fmt)
            FMT_R:        return 1'b0;
            FMT_I, FMT_S: return !in_range(imm, -32'sd2048, 32'sd2047);
            FMT_B:        return !in_range(imm, -32'sd4096, 32'sd4094) || imm[0];
            FMT_U:        return !in_range(imm, -32'sd524288, 32'sd524287);
            FMT_J:        return !in_range(imm, -32'sd1048576, 32'sd1048574) || imm[0];
            default:      return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] encode(
        input logic        [2:0]  fmt,
        input logic        [6:0]  op,
        input logic        [4:0]  rd,
        input logic        [4:0]  rs1,
        input logic        [4:0]  rs2,
        input logic        [2:0]  f3,
        input logic        [6:0]  f7,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[19:0], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    logic                     vld_p1;
    logic [2:0]               fmt_p1;
    logic [6:0]               op_p1;
    logic [4:0]               rd_p1;
    logic [4:0]               rs1_p1;
    logic [4:0]               rs2_p1;
    logic [2:0]               f3_p1;
    logic [6:0]               f7_p1;
    logic signed [31:0]       imm_p1;

    logic                     vld_p2;
    logic [31:0]              instr_p2;
    logic                     err_p2;
    logic [ADDR_W-1:0]        addr_p2;

    logic [ADDR_W-1:0]        addr_cnt;
    logic [15:0]              err_cnt_r;

    logic                     s2_free;
    logic                     accept;
    logic [31:0]              enc_word;
    logic                     enc_err;

    assign s2_free  = !vld_p2 || out_ready;
    assign in_ready = rstn && !clr && (!vld_p1 || s2_free);
    assign accept   = in_valid && in_ready;

    assign enc_word = encode(fmt_p1, op_p1, rd_p1, rs1_p1, rs2_p1, f3_p1, f7_p1, imm_p1);
    assign enc_err  = imm_err(fmt_p1, imm_p1);

    // Stage 1: capture the field bundle
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
        if (accept) begin
            fmt_p1 <= in_fmt;
            op_p1  <= in_opcode;
            rd_p1  <= in_rd;
            rs1_p1 <= in_rs1;
            rs2_p1 <= in_rs2;
            f3_p1  <= in_funct3;
            f7_p1  <= in_funct7;
            imm_p1 <= in_imm;
        end
    end

    // Stage 2: encoded word, error flag and its address; held while the memory side stalls
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            vld_p2   <= 1'b0;
            instr_p2 <= 32'h0;
            err_p2   <= 1'b0;
            addr_p2  <= BASE;
            addr_cnt <= BASE;
        end else if (s2_free) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= enc_word;
                err_p2   <= enc_err;
                addr_p2  <= addr_cnt;
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            err_cnt_r <= 16'h0;
        end else if (vld_p2 && out_ready && err_p2 && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_addr  = addr_p2;
    assign out_err   = err_p2;
    assign err_cnt   = err_cnt_r;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembler-side counterpart of the core's immediate generator: packs register fields, opcode/funct and a 32-bit immediate into a 32-bit RV32I instruction word.
- Sits between the program loader front end and instruction-memory write port; emits each word with an auto-incrementing word address.
- Two-stage valid/ready pipeline, one word per cycle, with immediate range/alignment checking and an error counter.

Parameters:
ADDR_W, 14, width of instruction-memory word address
BASE_ADDR, 0, address loaded on reset and on clr

Ports:
clk  input  1  clock, all logic rising-edge
rstn  input  1  synchronous active-low reset
clr  input  1  synchronous: flush pipeline, addr<=BASE_ADDR, err_cnt<=0
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
in_opcode  input  7  placed in instr[6:0]
in_rd  input  5  instr[11:7] (R/I/U/J)
in_rs1  input  5  instr[19:15] (R/I/S/B)
in_rs2  input  5  instr[24:20] (R/S/B)
in_funct3  input  3  instr[14:12] (R/I/S/B)
in_funct7  input  7  instr[31:25] (R only)
in_imm  input  32  two's-complement immediate, decoder convention
out_valid  output  1  encoded word valid
out_ready  input  1  memory side accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  word address of out_instr
out_err  output  1  word had illegal fmt or immediate out of range/misaligned
err_cnt  output  16  saturating count of transferred words with out_err=1

Behaviour:
- Reset (rstn=0 at edge): both stage valids 0, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0; in_ready=1 from first cycle after reset.
- Handshake: transfer when valid&&ready. out_valid/out_instr/out_addr/out_err held stable while out_valid&&!out_ready. in_ready = !s1_valid || (s1 advances this cycle); no combinational path in_valid->out_valid.
- Stage1 registers the bundle. Stage2 registers encoded word, err, addr. Latency: accept at edge N -> out_valid at edge N+2 with out_ready held 1. Throughput 1/cycle; bubbles collapse when downstream stalls.
- Encoding: R: {funct7,rs2,rs1,f3,rd,op}. I: {imm[11:0],rs1,f3,rd,op}. S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}. B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. U: {imm[19:0],rd,op} (imm is the unshifted 20-bit field, sign-extended). J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range checks (err=1 if violated): I,S in [-2048,2047]; B in [-4096,4094] and imm[0]=0; U in [-524288,524287]; J in [-1048576,1048574] and imm[0]=0; R ignores imm. fmt 6/7: err=1, instr=32'h0.
- On err the word is still emitted (truncated fields) at its address; address still advances.
- out_addr: stage2 takes addr counter on load; counter increments by 1 at each stage1->stage2 load, wraps 2^ADDR_W-1 -> 0.
- err_cnt increments on output transfer with out_err=1; saturates at 16'hFFFF.
- clr: same cycle effect as reset except rstn priority; bundle presented with clr is dropped (in_ready forced 0 during clr). rstn low mid-stream discards in-flight words.

Test Plan:
- I-type fmt=1, op=7'h13, rd=1, rs1=2, f3=0, imm=-1, out_ready=1 -> 2 cycles later out_instr=32'hFFF10093, out_addr=0, out_err=0.
- B-type fmt=3, op=7'h63, rs1=1, rs2=2, f3=0, imm=-4 -> 32'hFE208EE3; imm=3 -> out_err=1, err_cnt=1.
- J-type fmt=5, op=7'h6F, rd=1, imm=2048 -> 32'h001000EF; imm=1048576 -> out_err=1.
- Stream 4 back-to-back bundles, out_ready low cycles 2-4 -> no loss/duplication, outputs stable while stalled, addrs 0,1,2,3, in_ready drops when both stages full.
- ADDR_W=2: 5 words -> addrs 0,1,2,3,0; assert clr mid-stream -> out_valid=0 next cycle, next word addr=BASE_ADDR, err_cnt=0.
- fmt=7 -> out_instr=0, out_err=1; rstn=0 with words in flight -> out_valid=0, err_cnt=0 next cycle.
